// File: rtl/ps2_keyboard_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
// Receive FSM states, scancode type and the frame validity rule.
package ps2_keyboard_pkg;

  // Receive FSM states, one per part of the device-to-host frame.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_e;

  // Number of data bits carried by one frame.
  localparam int unsigned DATA_BITS = 8;

  // One keyboard scancode.
  typedef logic [DATA_BITS-1:0] scancode_t;

  // A frame is good when the stop bit is high and data plus parity has odd parity.
  function automatic logic frame_ok(input scancode_t data, input logic parity, input logic stop);
    return stop & (^{data, parity});
  endfunction

endpackage

// File: rtl/ps2_scancode_fifo.sv
// Synchronous scancode queue of 2**DEPTH_LOG2 entries.
// DEPTH_LOG2 = 0 collapses to a single holding register.
// A push to a full queue is accepted when a pop happens in the same cycle.
module ps2_scancode_fifo
  import ps2_keyboard_pkg::*;
#(
  parameter int DEPTH_LOG2 = 3
) (
  input  logic      clock_i,
  input  logic      reset_n_i,
  input  logic      push_i,
  input  scancode_t push_data_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output scancode_t head_data_o
);

  logic do_push;
  logic do_pop;

  // A pop on an empty queue is ignored; a pop frees a slot for a same-cycle push.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  generate
    if (DEPTH_LOG2 == 0) begin : g_hold
      logic      valid_q;
      scancode_t data_q;

      // Single holding register: a push overwrites, otherwise a pop empties it.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          valid_q <= 1'b0;
          data_q  <= '0;
        end else if (do_push) begin
          valid_q <= 1'b1;
          data_q  <= push_data_i;
        end else if (do_pop) begin
          valid_q <= 1'b0;
        end
      end

      assign full_o      = valid_q;
      assign empty_o     = ~valid_q;
      assign head_data_o = data_q;
    end else begin : g_ring
      localparam int DEPTH = 1 << DEPTH_LOG2;

      scancode_t             mem_q [DEPTH];
      logic [DEPTH_LOG2-1:0] wr_ptr_q;
      logic [DEPTH_LOG2-1:0] rd_ptr_q;
      logic [DEPTH_LOG2:0]   count_q;

      // Storage array, written at the tail; no reset so it can map to RAM.
      always_ff @(posedge clock_i) begin
        if (do_push) begin
          mem_q[wr_ptr_q] <= push_data_i;
        end
      end

      // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          wr_ptr_q <= '0;
          rd_ptr_q <= '0;
          count_q  <= '0;
        end else begin
          if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
          if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
          case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
          endcase
        end
      end

      assign empty_o     = (count_q == '0);
      assign full_o      = (count_q == (DEPTH_LOG2 + 1)'(DEPTH));
      assign head_data_o = mem_q[rd_ptr_q];
    end
  endgenerate

endmodule

// File: rtl/ps2_keyboard_receiver.sv
// PS/2 keyboard receiver: synchronises the PS/2 pins, deserialises and
// checks frames, queues good scancodes and presents the head as IRQ1/port A.
// Build option: define PS2_KEYBOARD_FIFO_EN for a 2**fifo_depth_log2 queue;
// otherwise a single holding register is used.
module ps2_keyboard_receiver
  import ps2_keyboard_pkg::*;
#(
  parameter logic [15:0] over_time       = 16'd1000,
  parameter int          fifo_depth_log2 = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       device_clock,
  input  logic       device_data,
  input  logic       clear_keycode,
  output logic       irq,
  output logic [7:0] keycode,
  output logic       frame_error,
  output logic       overflow
);

`ifdef PS2_KEYBOARD_FIFO_EN
  localparam int QUEUE_LOG2 = fifo_depth_log2;
`else
  localparam int QUEUE_LOG2 = 0;
  localparam int unused_fifo_depth_log2 = fifo_depth_log2;
`endif

  localparam int BIT_CNT_W = $clog2(DATA_BITS);

  // Pin synchroniser: bit 1 is the PS/2 clock, bit 0 the PS/2 data.
  logic [1:0] pin_meta_q;
  logic [1:0] pin_sync_q;
  logic       clk_prev_q;
  logic       fall;
  logic       rx_data;

  // Receive FSM and timeout state.
  rx_state_e              state_q, state_d;
  logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  scancode_t              shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [15:0]            to_cnt_q;
  logic                   timeout;
  logic                   push;
  logic                   err_d;

  // Queue and host side.
  logic      clr_prev_q;
  logic      pop;
  logic      q_full;
  logic      q_empty;
  scancode_t q_head;
  logic      q_drop;
  logic      avail_q;
  scancode_t head_q;
  logic      frame_error_q;
  logic      overflow_q;

  // Two-flop synchronisers plus the previous synchronised clock for edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pin_meta_q <= 2'b11;
      pin_sync_q <= 2'b11;
      clk_prev_q <= 1'b1;
    end else begin
      pin_meta_q <= {device_clock, device_data};
      pin_sync_q <= pin_meta_q;
      clk_prev_q <= pin_sync_q[1];
    end
  end

  assign fall    = clk_prev_q & ~pin_sync_q[1];
  assign rx_data = pin_sync_q[0];

  // Inter-edge idle counter: cleared on each falling edge, saturating, counts only mid-frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (fall) begin
      to_cnt_q <= '0;
    end else if ((state_q != IDLE) && (to_cnt_q != 16'hFFFF)) begin
      to_cnt_q <= to_cnt_q + 16'd1;
    end
  end

  assign timeout = (state_q != IDLE) && !fall && (to_cnt_q == over_time - 16'd1);

  // Receive FSM registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
    end
  end

  // Receive FSM next state: one action per falling edge, timeout aborts the frame.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    push      = 1'b0;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = IDLE;
      err_d   = 1'b1;
    end else if (fall) begin
      case (state_q)
        IDLE: begin
          if (!rx_data) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shift_d   = {rx_data, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BIT_CNT_W'(DATA_BITS - 1)) begin
            state_d = PARITY;
          end
        end
        PARITY: begin
          parity_d = rx_data;
          state_d  = STOP;
        end
        STOP: begin
          if (frame_ok(shift_q, parity_q, rx_data)) begin
            push = 1'b1;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  ps2_scancode_fifo #(
    .DEPTH_LOG2 (QUEUE_LOG2)
  ) u_fifo (
    .clock_i     (clock),
    .reset_n_i   (reset_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (pop),
    .full_o      (q_full),
    .empty_o     (q_empty),
    .head_data_o (q_head)
  );

  // Acknowledge is a rising edge of clear_keycode; a pop frees room for a same-cycle push.
  assign pop    = clear_keycode & ~clr_prev_q;
  assign q_drop = push & q_full & ~(pop & ~q_empty);

  // Registered host-side view of the queue head and the error pulses.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clr_prev_q    <= 1'b0;
      avail_q       <= 1'b0;
      head_q        <= '0;
      frame_error_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      clr_prev_q    <= clear_keycode;
      avail_q       <= ~q_empty;
      head_q        <= q_head;
      frame_error_q <= err_d;
      overflow_q    <= q_drop;
    end
  end

  // Mask while acknowledge is high and for the clock after, so the popped head never reappears.
  assign irq         = avail_q & ~clear_keycode & ~clr_prev_q;
  assign keycode     = irq ? head_q : 8'h00;
  assign frame_error = frame_error_q;
  assign overflow    = overflow_q;

endmodule
